regfile_banked: RTL
===================

# regfile_banked

Parametrised multi-bank architectural register file for the CPU core, the successor to the fixed two-bank integer/FPU register file. It provides N combinational read ports with write-back bypass and two write-back ports. A per-register scoreboard tracks destinations issued but not yet written back, giving the ID stage a hazard indication, and a registered debug read port replaces the hard-wired output register. It sits between ID (reads, issue) and WB (writes).

## Interface
- XLEN, 32, data width
- NREG, 32, registers per bank (power of two ≥2); AW = clog2(NREG)
- NBANK, 2, number of banks (bank 0 = integer, bank 1 = FPU, further banks free); BW = max(1, clog2(NBANK))
- NRD, 2, number of read ports
- clk  in  1  clock, rising edge
- rstn  in  1  reset, synchronous, active-low
- rd_bank  in  NRD*BW  read bank select, port k at [k*BW +: BW]
- rd_addr  in  NRD*AW  read register index per port
- rd_data  out  NRD*XLEN  read data per port, combinational
- rd_busy  out  NRD  scoreboard bit of the addressed register after same-cycle write-back clear, combinational
- wr_en  in  2  write-back enable, ports 0 and 1
- wr_bank  in  2*BW  write bank per port
- wr_addr  in  2*AW  write register index per port
- wr_data  in  2*XLEN  write data per port
- iss_en  in  1  mark destination pending
- iss_bank  in  BW  destination bank
- iss_addr  in  AW  destination index
- flush  in  1  clear all scoreboard bits
- dbg_bank  in  BW  debug read bank
- dbg_addr  in  AW  debug read index
- dbg_data  out  XLEN  registered debug read data
- pending_cnt  out  AW+BW+1  registered count of set scoreboard bits

## Operation
- Storage: NBANK×NREG×XLEN; scoreboard NBANK×NREG bits.
- Read port k: if a write port is enabled with matching bank and address, that port's wr_data is returned; if both ports match, port 1 wins. Otherwise the stored value is returned.
- Write: each enabled port writes on the clock edge. Both ports targeting the same bank/address: port 1 data is stored.
- Bank or address value ≥ NBANK/NREG on any input: write and issue are ignored, reads return 0, rd_busy = 0.
- Scoreboard update order per edge:
  1. flush clears all bits.
  2. Enabled write ports clear their target bits.
  3. iss_en sets its target bit.
- Consequence: issue wins over a same-cycle write-back or flush to the same register.
- rd_busy[k] = stored bit AND NOT (same-cycle write matching port k's bank/address). iss in the same cycle does not affect rd_busy.
- dbg_data captures the bypassed read value of dbg_bank/dbg_addr each edge.
- pending_cnt is the popcount of the next scoreboard state, registered.

## Timing
- Reads, bypass and rd_busy: 0-cycle combinational.
- Write visible in storage one edge after wr_en.
- Issue is visible on rd_busy the cycle after iss_en.
- dbg_data latency: 1 cycle.
- pending_cnt is coherent with the scoreboard on every cycle.
- Reset (rstn = 0 at edge): all registers, scoreboard bits, dbg_data and pending_cnt become 0. Writes, issue and flush in that cycle are discarded. Reset mid-operation loses pending state; no recovery is required.
- pending_cnt maximum NBANK*NREG: the width AW+BW+1 is sufficient, no saturation.

## Configuration
- RF_ZERO_REG_EN defined: bank 0 register 0 is hard-wired zero.
  - Reads and bypass return 0 for it, writes are ignored, iss_en never sets its bit, and rd_busy for it is always 0.
- Undefined: bank 0 register 0 is an ordinary register.
- Other banks are unaffected in both cases.

## Test plan
- Reset, then read every bank/address on all ports -> rd_data 0, rd_busy 0, pending_cnt 0, dbg_data 0.
- Port 0 writes bank 1 reg 5 = 0x3F800000 while read port 0 addresses it -> same cycle rd_data 0x3F800000; next cycle same value from storage; bank 0 reg 5 still 0.
- Both ports write bank 0 reg 7 (0x11, 0x22) in one cycle -> bypass and storage give 0x22.
- iss bank 0 reg 3 -> next cycle rd_busy 1, pending_cnt 1; write-back reg 3 = 0x55 -> rd_busy 0 that cycle with data 0x55, pending_cnt 0 next cycle; issue and write-back reg 3 in the same cycle -> busy stays 1.
- Issue 4 distinct registers, then flush with a concurrent iss to bank 1 reg 2 -> pending_cnt 1, only bank 1 reg 2 busy.
- With RF_ZERO_REG_EN, write 0xFFFF to bank 0 reg 0 and issue it -> reads 0, busy 0, pending_cnt 0; without the macro, reads 0xFFFF.

Source files
------------

// File: rtl/regfile_banked_if.sv
// Bus between ID/WB and the banked register file: read, write-back, issue, flush and debug signals.
interface regfile_banked_if #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int NBANK = 2,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(NREG);
    localparam int BW = (NBANK > 1) ? $clog2(NBANK) : 1;
    localparam int CW = AW + BW + 1;

    logic [NRD*BW-1:0]   rd_bank;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [1:0]          wr_en;
    logic [2*BW-1:0]     wr_bank;
    logic [2*AW-1:0]     wr_addr;
    logic [2*XLEN-1:0]   wr_data;
    logic                iss_en;
    logic [BW-1:0]       iss_bank;
    logic [AW-1:0]       iss_addr;
    logic                flush;
    logic [BW-1:0]       dbg_bank;
    logic [AW-1:0]       dbg_addr;
    logic [XLEN-1:0]     dbg_data;
    logic [CW-1:0]       pending_cnt;

    modport master (
        output rd_bank, rd_addr, wr_en, wr_bank, wr_addr, wr_data,
               iss_en, iss_bank, iss_addr, flush, dbg_bank, dbg_addr,
        input  rd_data, rd_busy, dbg_data, pending_cnt
    );

    modport slave (
        input  rd_bank, rd_addr, wr_en, wr_bank, wr_addr, wr_data,
               iss_en, iss_bank, iss_addr, flush, dbg_bank, dbg_addr,
        output rd_data, rd_busy, dbg_data, pending_cnt
    );
endinterface

// File: rtl/regfile_banked.sv
// Multi-bank register file with write-back bypass, per-register scoreboard and registered debug read.
// Optional macro RF_ZERO_REG_EN: bank 0 register 0 reads as zero and can neither be written nor issued.
module regfile_banked #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int NBANK = 2,
    parameter int NRD   = 2
) (
    input  logic            clk,
    input  logic            rstn,
    regfile_banked_if.slave bus
);
    localparam int AW   = $clog2(NREG);
    localparam int BW   = (NBANK > 1) ? $clog2(NBANK) : 1;
    localparam int CW   = AW + BW + 1;
    localparam int NENT = NBANK * NREG;
    localparam int NLK  = NRD + 1;   // read ports plus the debug lookup
`ifdef RF_ZERO_REG_EN
    localparam bit ZERO_REG_EN = 1'b1;
`else
    localparam bit ZERO_REG_EN = 1'b0;
`endif

    typedef logic [BW-1:0]    bank_t;
    typedef logic [AW-1:0]    addr_t;
    typedef logic [AW+BW-1:0] idx_t;

    logic [XLEN-1:0] mem_r [NENT];
    logic [NENT-1:0] sb_r;
    logic [NENT-1:0] sb_nxt_s;
    logic [NENT-1:0] clr_s;
    logic [NENT-1:0] set_s;
    logic [XLEN-1:0] dbg_data_r;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   cnt_nxt_s;

    bank_t           wb_s [2];
    addr_t           wa_s [2];
    logic [XLEN-1:0] wd_s [2];
    logic [1:0]      wv_s;
    logic            iv_s;

    bank_t           lb_s [NLK];
    addr_t           la_s [NLK];
    logic [NLK-1:0]  lv_s;
    logic [1:0]      hit_s [NLK];
    logic [XLEN-1:0] ld_s [NLK];
    logic [NRD-1:0]  rd_busy_s;

    // A target is real storage only if its bank exists and it is not the hard-wired zero register.
    function automatic logic ok_target(bank_t b, addr_t a);
        logic zero_hit;
        zero_hit = (b == {BW{1'b0}}) && (a == {AW{1'b0}});
        return (int'(b) < NBANK) && !(ZERO_REG_EN && zero_hit);
    endfunction

    // Split packed bus fields into per-port bank/address/data and qualify each target.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            wb_s[p] = bus.wr_bank[p*BW +: BW];
            wa_s[p] = bus.wr_addr[p*AW +: AW];
            wd_s[p] = bus.wr_data[p*XLEN +: XLEN];
            wv_s[p] = bus.wr_en[p] && ok_target(wb_s[p], wa_s[p]);
        end
        for (int k = 0; k < NRD; k++) begin
            lb_s[k] = bus.rd_bank[k*BW +: BW];
            la_s[k] = bus.rd_addr[k*AW +: AW];
            lv_s[k] = ok_target(lb_s[k], la_s[k]);
        end
        lb_s[NRD] = bus.dbg_bank;
        la_s[NRD] = bus.dbg_addr;
        lv_s[NRD] = ok_target(bus.dbg_bank, bus.dbg_addr);
        iv_s      = bus.iss_en && ok_target(bus.iss_bank, bus.iss_addr);
    end

    // Bypassed lookup: write port 1 beats port 0, which beats storage.
    always_comb begin
        for (int k = 0; k < NLK; k++) begin
            for (int p = 0; p < 2; p++) begin
                hit_s[k][p] = wv_s[p] && (wb_s[p] == lb_s[k]) && (wa_s[p] == la_s[k]);
            end
            if (hit_s[k][1]) begin
                ld_s[k] = wd_s[1];
            end else if (hit_s[k][0]) begin
                ld_s[k] = wd_s[0];
            end else if (lv_s[k]) begin
                ld_s[k] = mem_r[idx_t'({lb_s[k], la_s[k]})];
            end else begin
                ld_s[k] = {XLEN{1'b0}};
            end
        end
    end

    // Busy reflects the stored bit minus any same-cycle write-back; same-cycle issue is not seen.
    always_comb begin
        for (int k = 0; k < NRD; k++) begin
            rd_busy_s[k] = (lv_s[k] ? sb_r[idx_t'({lb_s[k], la_s[k]})] : 1'b0) &&
                           (hit_s[k] == 2'b00);
        end
    end

    // Next scoreboard: flush, then write-back clears, then issue sets, so issue always wins.
    always_comb begin
        clr_s = ({{(NENT-1){1'b0}}, wv_s[0]} << idx_t'({wb_s[0], wa_s[0]})) |
                ({{(NENT-1){1'b0}}, wv_s[1]} << idx_t'({wb_s[1], wa_s[1]}));
        set_s = {{(NENT-1){1'b0}}, iv_s} << idx_t'({bus.iss_bank, bus.iss_addr});
        sb_nxt_s = ((bus.flush ? {NENT{1'b0}} : sb_r) & ~clr_s) | set_s;
        cnt_nxt_s = {CW{1'b0}};
        for (int i = 0; i < NENT; i++) begin
            cnt_nxt_s = cnt_nxt_s + CW'(sb_nxt_s[i]);
        end
    end

    // Storage, scoreboard and registered outputs; reset also discards same-cycle writes and issues.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NENT; i++) begin
                mem_r[i] <= {XLEN{1'b0}};
            end
            sb_r       <= {NENT{1'b0}};
            dbg_data_r <= {XLEN{1'b0}};
            cnt_r      <= {CW{1'b0}};
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (wv_s[p]) begin
                    mem_r[idx_t'({wb_s[p], wa_s[p]})] <= wd_s[p];
                end
            end
            sb_r       <= sb_nxt_s;
            dbg_data_r <= ld_s[NRD];
            cnt_r      <= cnt_nxt_s;
        end
    end

    // Drive the bus outputs.
    always_comb begin
        bus.rd_data = {(NRD*XLEN){1'b0}};
        for (int k = 0; k < NRD; k++) begin
            bus.rd_data[k*XLEN +: XLEN] = ld_s[k];
        end
        bus.rd_busy     = rd_busy_s;
        bus.dbg_data    = dbg_data_r;
        bus.pending_cnt = cnt_r;
    end
endmodule
